// File: rtl/split2_pkg.sv
// Shared state types and pointer-width helper for the 2-way retire splitter.
package split2_pkg;

  typedef enum logic {IN_RDY = 1'b0, IN_HOLD = 1'b1} in_state_t;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_WAIT = 1'b1} out_state_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/split2_chan_q.sv
// One output channel: QDEPTH-entry queue plus drive/free handshake FSM.
// state    | meaning
// OUT_IDLE | no token offered; drive when queue non-empty
// OUT_WAIT | head offered, waiting for consumer free pulse
module split2_chan_q
  import split2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  free_next,
  output logic                  space,
  output logic                  waiting,
  output logic                  drive,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = ptr_width(QDEPTH);

  logic [DATA_WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] data_q;
  out_state_t            state;
  logic                  empty;
  logic                  full;
  logic                  pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = (state == OUT_WAIT) && free_next;
  // a pop in the same cycle frees the slot the push lands in
  assign space   = !full || pop;
  assign waiting = (state == OUT_WAIT);
  assign drive   = (state == OUT_IDLE) && !empty;
  assign data    = drive ? mem[rd_ptr[AW-1:0]] : data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_q <= '0;
      state  <= OUT_IDLE;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        OUT_IDLE: if (!empty) begin
          state  <= OUT_WAIT;
          data_q <= mem[rd_ptr[AW-1:0]];
        end
        OUT_WAIT: if (free_next) state <= OUT_IDLE;
        default:  state <= OUT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/c_split2_n_retire_sync.sv
// 1-to-2 token splitter with hold register and per-output queues.
// Optional broadcast of bit SEL_BIT+1 when SPLIT2_BCAST_EN is defined.
// state   | meaning
// IN_RDY  | hold register empty, accepting i_drive
// IN_HOLD | token held, waiting for destination queue space
module c_split2_n_retire_sync
  import split2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_BIT    = 0,
  parameter int QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic [1:0]            o_drive_2,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  input  logic [1:0]            i_freeNext_2,
  output logic                  o_err
);

  in_state_t             in_state;
  logic [DATA_WIDTH-1:0] hold;
  logic [1:0]            dest;
  logic [1:0]            space;
  logic [1:0]            push;
  logic [1:0]            waiting;
  logic                  accept;
  logic                  err_now;

  always_comb begin
    dest = hold[SEL_BIT] ? 2'b10 : 2'b01;
`ifdef SPLIT2_BCAST_EN
    if (hold[SEL_BIT+1]) dest = 2'b11;
`endif
    // broadcast only proceeds when every destination can take it at once
    accept = (in_state == IN_HOLD) && ((space & dest) == dest);
    push   = accept ? dest : 2'b00;
  end

  assign o_free  = accept;
  assign err_now = (i_drive && (in_state == IN_HOLD)) || |(i_freeNext_2 & ~waiting);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state <= IN_RDY;
      hold     <= '0;
      o_err    <= 1'b0;
    end else begin
      if (err_now) o_err <= 1'b1;
      case (in_state)
        IN_RDY: if (i_drive) begin
          hold     <= i_data;
          in_state <= IN_HOLD;
        end
        IN_HOLD: if (accept) in_state <= IN_RDY;
        default: in_state <= IN_RDY;
      endcase
    end
  end

  split2_chan_q #(.DATA_WIDTH(DATA_WIDTH), .QDEPTH(QDEPTH)) u_chan0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[0]),
    .push_data (hold),
    .free_next (i_freeNext_2[0]),
    .space     (space[0]),
    .waiting   (waiting[0]),
    .drive     (o_drive_2[0]),
    .data      (o_data0)
  );

  split2_chan_q #(.DATA_WIDTH(DATA_WIDTH), .QDEPTH(QDEPTH)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[1]),
    .push_data (hold),
    .free_next (i_freeNext_2[1]),
    .space     (space[1]),
    .waiting   (waiting[1]),
    .drive     (o_drive_2[1]),
    .data      (o_data1)
  );

endmodule
